// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bo = borrow out.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first, one bit per clock,
// with a start/ready/busy/done handshake and registered result flags.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             cell_d, cell_bo;

  fullsubtractor u_cell (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .bin (borrow_q),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // State register and all datapath/output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d     = A;
          sb_d     = B;
          borrow_d = Bin;
          amsb_d   = A[WIDTH-1];
          bmsb_d   = B[WIDTH-1];
          cnt_d    = '0;
          state_d  = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d    = {cell_d, res_q[WIDTH-1:1]};
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        borrow_d = cell_bo;
        if (cnt_q == CNT_LAST) begin
          // Final bit: cell_d is the result MSB, cell_bo the borrow-out.
          state_d = DONE;
          done_d  = 1'b1;
          bout_d  = cell_bo;
          ovf_d   = (amsb_q ^ bmsb_q) & (cell_d ^ amsb_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == RUN);
    ready_d = ~busy_d;
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign D     = res_q;
  assign Bout  = bout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] D;
  logic       Bout;
  logic       ovf;

  int pass_cnt;
  int total_cnt;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and observe a fixed 12-cycle window (sampled at negedge).
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d_o, output logic bo_o, output logic ov_o,
                       output int busy_n, output int done_n, output int done_at,
                       output int overlap_n);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; overlap_n = 0;
    d_o = 8'h00; bo_o = 1'b0; ov_o = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (busy && done) overlap_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = i; d_o = D; bo_o = Bout; ov_o = ovf;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; Bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({ready, busy, done, D, Bout, ovf} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_state: got rdy=%b busy=%b done=%b D=%h bo=%b ovf=%b, want 1 0 0 00 0 0",
               ready, busy, done, D, Bout, ovf);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({ready, busy, done} !== 3'b100)
      $display("FAIL idle_after_reset: got rdy/busy/done=%b, want 100", {ready, busy, done});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [7:0] ta [6] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00, 8'hA5};
    logic [7:0] tb [6] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'h5A};
    logic       ti [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] ed [6] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'hFF, 8'h4A};
    logic       eb [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] d; logic bo, ov; int bn, dn, da, ovl;
    for (int k = 0; k < 6; k++) begin
      do_op(ta[k], tb[k], ti[k], d, bo, ov, bn, dn, da, ovl);
      total_cnt++;
      if (bn !== 8 || dn !== 1 || da !== 9 || ovl !== 0)
        $display("FAIL timing_%0d: got busy=%0d done=%0d at=%0d overlap=%0d, want 8 1 9 0",
                 k, bn, dn, da, ovl);
      else pass_cnt++;
      total_cnt++;
      if ({d, bo, ov} !== {ed[k], eb[k], eo[k]})
        $display("FAIL result_%0d: %h-%h-%b got D=%h bo=%b ovf=%b, want D=%h bo=%b ovf=%b",
                 k, ta[k], tb[k], ti[k], d, bo, ov, ed[k], eb[k], eo[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({ready, D, Bout, ovf} !== {1'b1, 8'h4A, 1'b0, 1'b1})
      $display("FAIL hold_in_idle: got rdy=%b D=%h bo=%b ovf=%b, want 1 4a 0 1", ready, D, Bout, ovf);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int first_done, second_done, busy_n;
    logic [7:0] d1, d2; logic b1, b2, o2;
    first_done = -1; second_done = -1; busy_n = 0;
    d1 = 8'h00; d2 = 8'h00; b1 = 1'b0; b2 = 1'b0; o2 = 1'b0;
    @(negedge clk);
    A = 8'h00; B = 8'h00; Bin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done && first_done < 0) begin
        first_done = i; d1 = D; b1 = Bout;
        A = 8'hFF; B = 8'h0F; Bin = 1'b0; start = 1'b1;
      end else if (done) begin
        second_done = i; d2 = D; b2 = Bout; o2 = ovf;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    total_cnt++;
    if (first_done !== 9 || d1 !== 8'hFF || b1 !== 1'b1)
      $display("FAIL b2b_first: got at=%0d D=%h bo=%b, want 9 ff 1", first_done, d1, b1);
    else pass_cnt++;
    total_cnt++;
    if (second_done !== 18 || busy_n !== 16)
      $display("FAIL b2b_gap: got second done at=%0d busy=%0d, want 18 16", second_done, busy_n);
    else pass_cnt++;
    total_cnt++;
    if ({d2, b2, o2} !== {8'hF0, 1'b0, 1'b0})
      $display("FAIL b2b_second: got D=%h bo=%b ovf=%b, want f0 0 0", d2, b2, o2);
    else pass_cnt++;
  endtask

  task automatic test_start_during_run();
    int done_n;
    logic [7:0] d; logic bo, ov;
    done_n = 0; d = 8'h00; bo = 1'b0; ov = 1'b0;
    @(negedge clk);
    A = 8'h7F; B = 8'hFF; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 3) begin
        A = 8'h05; B = 8'h03; Bin = 1'b1; start = 1'b1;
      end else if (i == 5) begin
        start = 1'b0;
      end
      if (done) begin
        done_n++; d = D; bo = Bout; ov = ovf;
      end
    end
    total_cnt++;
    if (done_n !== 1)
      $display("FAIL ignore_start_pulses: got %0d done pulses, want 1", done_n);
    else pass_cnt++;
    total_cnt++;
    if ({d, bo, ov} !== {8'h80, 1'b1, 1'b1})
      $display("FAIL ignore_start_result: got D=%h bo=%b ovf=%b, want 80 1 1", d, bo, ov);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int done_n, bn, da, ovl;
    logic [7:0] d; logic bo, ov;
    logic busy4;
    done_n = 0;
    @(negedge clk);
    A = 8'h33; B = 8'h11; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    busy4 = busy;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy4, ready, busy, done, D, Bout, ovf} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_mid_run: got busy4=%b rdy=%b busy=%b done=%b D=%h bo=%b ovf=%b, want 1 1 0 0 00 0 0",
               busy4, ready, busy, done, D, Bout, ovf);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_n++;
    end
    total_cnt++;
    if (done_n !== 0)
      $display("FAIL abort_no_done: got %0d cycles with done/busy, want 0", done_n);
    else pass_cnt++;
    do_op(8'h10, 8'h01, 1'b0, d, bo, ov, bn, done_n, da, ovl);
    total_cnt++;
    if ({d, bo, ov} !== {8'h0F, 1'b0, 1'b0} || da !== 9 || done_n !== 1)
      $display("FAIL after_reset_op: got D=%h bo=%b ovf=%b at=%0d n=%0d, want 0f 0 0 9 1",
               d, bo, ov, da, done_n);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_during_run();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing D = A − B − Bin one bit per clock, LSB first, through a single one-bit full-subtractor cell with a registered borrow. It sits downstream of the one-bit `fullsubtractor` cell. It wraps that cell into a multi-bit arithmetic unit with a start/done handshake, so datapath logic can trade area for latency.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- A  input  WIDTH  minuend, captured on accepted start
- B  input  WIDTH  subtrahend, captured on accepted start
- Bin  input  1  borrow-in, captured on accepted start
- ready  output  1  high in IDLE and DONE; start accepted
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; result valid
- D  output  WIDTH  difference (A − B − Bin) mod 2^WIDTH
- Bout  output  1  final borrow-out; 1 when A < B + Bin unsigned
- ovf  output  1  two's-complement overflow of the signed subtraction

## Operation
- States: IDLE, RUN, DONE; encoding constants live in the shared package.
- IDLE/DONE with start=1:
  - Load shift registers sa←A, sb←B, borrow←Bin.
  - Clear the bit counter and go to RUN.
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- RUN, every cycle:
  - The cell computes d = sa[0]^sb[0]^borrow and bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow).
  - Shift d into D's result register from the MSB side (right shift), so bit i lands at D[i] after WIDTH shifts.
  - Shift sa and sb right; borrow←bo; counter++.
- RUN when the counter reaches WIDTH−1: the final shift completes; go to DONE.
- On entry to DONE: Bout←final bo; ovf←(A[MSB]≠B[MSB]) & (D[MSB]≠A[MSB]), using the captured A/B MSBs.
- D, Bout and ovf hold their values from DONE through IDLE until the next accepted start. During RUN, D is a partially shifted value and is not valid.
- start while busy=1 is ignored; A/B/Bin changes during RUN have no effect.
- Counter width: $clog2(WIDTH); no wrap beyond WIDTH−1.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - State goes to IDLE.
  - D=0, Bout=0, ovf=0, done=0, busy=0, ready=1; internal registers cleared.
  - An aborted operation produces no done.
- Latency: start accepted at edge k → busy during cycles k+1..k+WIDTH → done=1 for exactly the cycle after edge k+WIDTH. D/Bout/ovf are valid in that same cycle.
- Throughput: start asserted in the done cycle is accepted, giving back-to-back operations every WIDTH+1 cycles with no idle gap.
- done and busy are never high together; ready = ~busy.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package serial_subtractor_pkg: state encoding constants (IDLE, RUN, DONE) and the default WIDTH.
- One sub-module: the existing `fullsubtractor` one-bit cell, instantiated once, with inputs sa[0], sb[0], borrow and outputs d, bo.
- The top level holds the FSM, counter, shift registers and result/flag registers.

## Test plan
All scenarios use WIDTH=8.
- A=0x05, B=0x03, Bin=0 → after 8 busy cycles, done pulse; D=0x02, Bout=0, ovf=0.
- A=0x03, B=0x05, Bin=0 → D=0xFE, Bout=1, ovf=0.
- A=0x80, B=0x01, Bin=0 → D=0x7F, Bout=0, ovf=1. Also A=0x7F, B=0xFF → D=0x80, Bout=1, ovf=1.
- A=0x00, B=0x00, Bin=1 → D=0xFF, Bout=1, ovf=0. Then start again in the done cycle with A=0xFF, B=0x0F → accepted with no gap; D=0xF0, Bout=0.
- Start during RUN with different operands → ignored; first result unchanged, exactly one done pulse.
- Assert rst at the 4th busy cycle → outputs zero immediately, ready=1, no done. A following start with A=0x10, B=0x01 → D=0x0F.
